bram_dump_reader: RTL and testbench

- Hardware reader for the CPU debug RAM port (A2/WD2/WE2/RD2 side of Inst/Data BRAM); the on-chip counterpart of the bench's loader/writer.
- On start, walks a contiguous word range through the debug port and streams {address, data} words out on a valid/ready interface.
- Feeds a UART/host dump path so BRAM contents can be read back on the Nexys4 board.
- Instantiated once per BRAM (InstRAM, DataRAM).

---
 rtl/bram_dump_pkg.sv | 34 +++
 rtl/dump_out_stage.sv | 59 +++++
 rtl/bram_dump_reader.sv | 174 +++++++++++++++++
 tb/tb_bram_dump_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_dump_pkg.sv
// bram_dump_pkg
//   Shared types and constants for the BRAM debug-port dump reader.
//   - state_t       : reader FSM state encoding
//   - DEBUG_WE_NONE : byte-enable value driven on the debug port (read only)
//   - WORD_BYTES    : byte stride between consecutive BRAM words
//   - COUNT_W       : width of the word_count request port
//   - sat_count()   : clamps a requested word count to the BRAM depth
package bram_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [3:0]  DEBUG_WE_NONE = 4'b0000;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int          COUNT_W       = 13;

  // A request larger than the memory would otherwise walk past the end of
  // the array and re-read low addresses; clamp it to the depth instead.
  function automatic logic [COUNT_W-1:0] sat_count(
    input logic [COUNT_W-1:0] req,
    input int unsigned        max_words
  );
    if (32'(req) > max_words) begin
      return COUNT_W'(max_words);
    end
    return req;
  endfunction

endpackage

// File: rtl/dump_out_stage.sv
// dump_out_stage
//   Single-entry output holding register for a valid/ready stream.
//   A load captures {addr, data, last} and raises out_valid; the entry is
//   held unchanged until the consumer accepts it (out_valid && out_ready),
//   after which out_valid drops. Payload registers keep their last value
//   after acceptance so downstream observers see a stable bus.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset, clears all outputs
//   load       in   capture load_* into the holding register
//   load_addr  in   address to present
//   load_data  in   data word to present
//   load_last  in   final-beat marker
//   out_ready  in   consumer ready
//   out_valid  out  stream valid
//   out_addr   out  held address
//   out_data   out  held data
//   out_last   out  held final-beat marker
//   accept     out  handshake strobe (out_valid && out_ready)
module dump_out_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              accept
);

  assign accept = out_valid && out_ready;

  // load wins over accept so a producer that reloads in the handshake cycle
  // gets back-to-back beats without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= load_addr;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_dump_reader.sv
// bram_dump_reader
//   Walks a contiguous word range of an Inst/Data BRAM through its debug
//   read port (A2/WD2/WE2/RD2) and streams {address, data} beats out on a
//   valid/ready interface toward the UART/host dump path. One instance per
//   BRAM. The debug port is never written.
//
//   Optional build macro: BRAM_DUMP_CHECKSUM_EN adds a `checksum` output
//   holding the wrapping sum of every data word accepted in the current dump.
//
// Ports
//   CPU_CLK     in   clock
//   CPU_RST     in   synchronous active-high reset
//   start       in   one-cycle start pulse, honoured only while idle
//   base_addr   in   first byte address (bits [1:0] ignored)
//   word_count  in   words to dump, 0 finishes immediately, clamped to MAX_WORDS
//   busy        out  dump in progress
//   done        out  one-cycle completion pulse
//   dbg_a2      out  debug-port byte address
//   dbg_wd2     out  debug-port write data (always zero)
//   dbg_we2     out  debug-port byte enables (always zero)
//   dbg_rd2     in   debug-port read data
//   out_valid   out  stream valid
//   out_ready   in   stream ready
//   out_addr    out  byte address of out_data
//   out_data    out  word read from the BRAM
//   out_last    out  marks the final word of the dump
//   checksum    out  (BRAM_DUMP_CHECKSUM_EN only) sum of accepted words
//
// FSM
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ISSUE | dbg_a2 presents cur_addr, latency counter loaded
//   S_WAIT  | waiting RD_LAT cycles for dbg_rd2, capture on the last one
//   S_SEND  | beat offered on the stream until accepted
//   S_FIN   | done pulse, back to idle
module bram_dump_reader
  import bram_dump_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 4096,
  parameter int RD_LAT    = 1
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  dbg_a2,
  output logic [DATA_W-1:0]  dbg_wd2,
  output logic [3:0]         dbg_we2,
  input  logic [DATA_W-1:0]  dbg_rd2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last
`ifdef BRAM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  checksum
`endif
);

  // RD_LAT is at least 1: the BRAM debug port is a registered read.
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [COUNT_W-1:0] remaining;
  logic [LAT_W-1:0]   lat_cnt;
  logic               capture;
  logic               accept;
  logic               start_ok;

  assign start_ok = (state == S_IDLE) && start;

  // The counter is loaded with RD_LAT in ISSUE and decremented every WAIT
  // cycle; the cycle in which it steps from 1 to 0 is the one where dbg_rd2
  // carries the word for dbg_a2, so WAIT lasts exactly RD_LAT cycles.
  assign capture = (state == S_WAIT) && (lat_cnt == LAT_W'(1));

  assign dbg_a2  = cur_addr;
  assign dbg_wd2 = '0;
  assign dbg_we2 = DEBUG_WE_NONE;

  assign busy = (state == S_ISSUE) || (state == S_WAIT) || (state == S_SEND);
  assign done = (state == S_FIN);

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              cur_addr  <= base_addr & ~ADDR_W'(3);
              remaining <= sat_count(word_count, MAX_WORDS);
              state     <= S_ISSUE;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_ISSUE: begin
          lat_cnt <= LAT_W'(RD_LAT);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (capture) begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (accept) begin
            // Address arithmetic wraps naturally at the top of the space.
            cur_addr  <= cur_addr + ADDR_W'(WORD_BYTES);
            remaining <= remaining - COUNT_W'(1);
            state     <= out_last ? S_FIN : S_ISSUE;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  dump_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk       (CPU_CLK),
    .rst       (CPU_RST),
    .load      (capture),
    .load_addr (cur_addr),
    .load_data (dbg_rd2),
    .load_last (remaining == COUNT_W'(1)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .accept    (accept)
  );

`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Cleared on any start taken in idle (including a zero-length one), so the
  // value read at done always belongs to the dump that just finished.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + out_data;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_bram_dump_reader.sv
module tb_bram_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [12:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] dbg_a2;
  logic [31:0] dbg_wd2;
  logic [3:0]  dbg_we2;
  logic [31:0] dbg_rd2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_last;
`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];

  bram_dump_reader dut (
    .CPU_CLK    (clk),
    .CPU_RST    (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .dbg_a2     (dbg_a2),
    .dbg_wd2    (dbg_wd2),
    .dbg_we2    (dbg_we2),
    .dbg_rd2    (dbg_rd2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef BRAM_DUMP_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered read, one cycle from address to data.
  // Only the low 1 KiB is backed; elsewhere the word is ~address.
  function automatic logic [31:0] bram_word(input logic [31:0] a);
    if (a[31:10] == 22'd0) return mem[a[9:2]];
    return ~a;
  endfunction

  always @(posedge clk) dbg_rd2 <= bram_word(dbg_a2);

  initial begin
    #1_000_000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps until out_valid (bounded), returns cycles taken, checks the beat.
  task automatic expect_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic l, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_addr"}, out_addr, a);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, 32'(out_last), 32'(l));
    check({tag, "_we2"}, 32'(dbg_we2), 32'd0);
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [12:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    int n;
    int beats;
    logic [31:0] last_addr;
    logic saw_last;

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    for (int i = 3; i < 10; i++) mem[i] = 32'hA000_0000 + 32'(i);

    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_a2", dbg_a2, 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", out_addr, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_we2", 32'(dbg_we2), 32'd0);
    check("rst_wd2", dbg_wd2, 32'd0);
    rst = 1'b0;
    tick();

    // three-word dump, ready held high
    pulse_start(32'h0, 13'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_a2", dbg_a2, 32'h0);
    check("t1_valid0", 32'(out_valid), 32'd0);
    expect_beat("t1_b0", 32'h0, 32'h1111_1111, 1'b0, n);
    check("t1_latency", 32'(n), 32'd2);
    expect_beat("t1_b1", 32'h4, 32'h2222_2222, 1'b0, n);
    check("t1_rate1", 32'(n), 32'd3);
    expect_beat("t1_b2", 32'h8, 32'h3333_3333, 1'b1, n);
    check("t1_rate2", 32'(n), 32'd3);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_fin", 32'(busy), 32'd0);
    check("t1_valid_fin", 32'(out_valid), 32'd0);
`ifdef BRAM_DUMP_CHECKSUM_EN
    check("t1_checksum", checksum, 32'h6666_6666);
`endif
    tick();
    check("t1_done_drop", 32'(done), 32'd0);

    // backpressure on beat 2 for five cycles
    pulse_start(32'h0, 13'd3);
    expect_beat("t2_b0", 32'h0, 32'h1111_1111, 1'b0, n);
    tick();
    out_ready = 1'b0;
    expect_beat("t2_b1", 32'h4, 32'h2222_2222, 1'b0, n);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_addr", out_addr, 32'h4);
      check("t2_hold_data", out_data, 32'h2222_2222);
    end
    out_ready = 1'b1;
    expect_beat("t2_b2", 32'h8, 32'h3333_3333, 1'b1, n);
    check("t2_rate", 32'(n), 32'd3);
    tick();
    check("t2_done", 32'(done), 32'd1);
    tick();

    // zero-length dump
    pulse_start(32'h40, 13'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_valid", 32'(out_valid), 32'd0);
`ifdef BRAM_DUMP_CHECKSUM_EN
    check("t3_checksum", checksum, 32'h0);
`endif
    tick();
    check("t3_done_drop", 32'(done), 32'd0);
    check("t3_valid2", 32'(out_valid), 32'd0);

    // unaligned base is rounded down
    pulse_start(32'h3, 13'd1);
    check("t4_a2", dbg_a2, 32'h0);
    expect_beat("t4_b0", 32'h0, 32'h1111_1111, 1'b1, n);
    tick();
    check("t4_done", 32'(done), 32'd1);
    tick();

    // address wrap at the top of the space
    pulse_start(32'hFFFF_FFFC, 13'd2);
    check("t5_a2", dbg_a2, 32'hFFFF_FFFC);
    expect_beat("t5_b0", 32'hFFFF_FFFC, 32'h0000_0003, 1'b0, n);
    expect_beat("t5_b1", 32'h0, 32'h1111_1111, 1'b1, n);
    tick();
    check("t5_done", 32'(done), 32'd1);
    tick();

    // reset in WAIT of word 5 of 10
    pulse_start(32'h0, 13'd10);
    expect_beat("t6_b0", 32'h0, 32'h1111_1111, 1'b0, n);
    expect_beat("t6_b1", 32'h4, 32'h2222_2222, 1'b0, n);
    expect_beat("t6_b2", 32'h8, 32'h3333_3333, 1'b0, n);
    expect_beat("t6_b3", 32'hC, 32'hA000_0003, 1'b0, n);
    tick();
    tick();
    check("t6_wait_a2", dbg_a2, 32'h10);
    check("t6_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_a2", dbg_a2, 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_addr", out_addr, 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_no_done", 32'(done), 32'd0);
    pulse_start(32'h0, 13'd2);
    expect_beat("t6_r0", 32'h0, 32'h1111_1111, 1'b0, n);
    expect_beat("t6_r1", 32'h4, 32'h2222_2222, 1'b1, n);
    tick();
    check("t6_done", 32'(done), 32'd1);
    tick();

    // oversize request clamps to 4096 words
    pulse_start(32'h0, 13'h1FFF);
    beats = 0;
    last_addr = '0;
    saw_last = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      if (out_valid) begin
        beats++;
        last_addr = out_addr;
        if (out_last) begin
          saw_last = 1'b1;
          break;
        end
      end
    end
    check("t7_saw_last", 32'(saw_last), 32'd1);
    check("t7_beats", 32'(beats), 32'd4096);
    check("t7_last_addr", last_addr, 32'h0000_3FFC);
    tick();
    check("t7_done", 32'(done), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
